// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes IF/ID, samples register-file operands,
// loads the ID/EX pipeline register and inserts load-use bubbles.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic [4:0]  r1_idx,
    output logic [4:0]  r2_idx,
    input  logic [31:0] reg1_data,
    input  logic [31:0] reg2_data,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [31:0] idex_rs1_data,
    output logic [31:0] idex_rs2_data,
    output logic [31:0] idex_imm,
    output logic [4:0]  idex_rs1,
    output logic [4:0]  idex_rs2,
    output logic [4:0]  idex_rd,
    output logic [6:0]  idex_opcode,
    output logic [2:0]  idex_funct3,
    output logic        idex_funct7b5,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } idex_t;

    idex_t       idex_q;
    idex_t       dec;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        wr_en;
    logic        ld;
    logic        st;
    logic        ill;
    logic        hz;

    assign opcode = if_instr[6:0];
    assign r1_idx = if_instr[19:15];
    assign r2_idx = if_instr[24:20];

    always_comb begin
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_en   = 1'b0;
        ld      = 1'b0;
        st      = 1'b0;
        ill     = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm   = {if_instr[31:12], 12'b0};
                wr_en = 1'b1;
            end
            OP_JAL: begin
                imm   = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
                wr_en = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                imm     = {{20{if_instr[31]}}, if_instr[31:20]};
                use_rs1 = 1'b1;
                wr_en   = 1'b1;
                ld      = (opcode == OP_LOAD);
            end
            OP_STORE: begin
                imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                st      = 1'b1;
            end
            OP_BRANCH: begin
                imm     = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_en   = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    end

    // Control bits are suppressed for an empty IF/ID slot; data fields load regardless.
    always_comb begin
        dec           = '0;
        dec.valid     = if_valid;
        dec.pc        = if_pc;
        dec.rs1_data  = reg1_data;
        dec.rs2_data  = reg2_data;
        dec.imm       = imm;
        dec.rs1       = if_instr[19:15];
        dec.rs2       = if_instr[24:20];
        dec.rd        = if_instr[11:7];
        dec.opcode    = opcode;
        dec.funct3    = if_instr[14:12];
        dec.funct7b5  = if_instr[30];
        dec.reg_write = if_valid && wr_en && (if_instr[11:7] != 5'd0);
        dec.mem_read  = if_valid && ld;
        dec.mem_write = if_valid && st;
        dec.illegal   = if_valid && ill;
    end

    assign hz = if_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                ((use_rs1 && (idex_q.rd == r1_idx)) || (use_rs2 && (idex_q.rd == r2_idx)));

    assign stall_o = rst_n && !flush_i && (hold_i || hz);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (flush_i) begin
            idex_q <= '0;
        end else if (hold_i) begin
            idex_q <= idex_q;
        end else if (hz) begin
            idex_q <= '0;
        end else begin
            idex_q <= dec;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_pc        = idex_q.pc;
    assign idex_rs1_data  = idex_q.rs1_data;
    assign idex_rs2_data  = idex_q.rs2_data;
    assign idex_imm       = idex_q.imm;
    assign idex_rs1       = idex_q.rs1;
    assign idex_rs2       = idex_q.rs2;
    assign idex_rd        = idex_q.rd;
    assign idex_opcode    = idex_q.opcode;
    assign idex_funct3    = idex_q.funct3;
    assign idex_funct7b5  = idex_q.funct7b5;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign idex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference decoder predicts each ID/EX load
// and stall_o; predictions are queued at drive time and popped after the edge.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  r1_idx;
    logic [4:0]  r2_idx;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic        flush_i;
    logic        hold_i;
    logic        stall_o;
    logic        idex_valid;
    logic [31:0] idex_pc;
    logic [31:0] idex_rs1_data;
    logic [31:0] idex_rs2_data;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs1;
    logic [4:0]  idex_rs2;
    logic [4:0]  idex_rd;
    logic [6:0]  idex_opcode;
    logic [2:0]  idex_funct3;
    logic        idex_funct7b5;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic        idex_mem_write;
    logic        idex_illegal;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .r1_idx(r1_idx), .r2_idx(r2_idx), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
        .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_opcode(idex_opcode),
        .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_illegal(idex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ho;
    } stim_t;

    // Mock register file: answers the DUT's read indices in the same cycle.
    logic [31:0] rf [32];
    assign reg1_data = rf[r1_idx];
    assign reg2_data = rf[r2_idx];

    exp_t obs;
    assign obs = {idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1,
                  idex_rs2, idex_rd, idex_opcode, idex_funct3, idex_funct7b5,
                  idex_reg_write, idex_mem_read, idex_mem_write, idex_illegal};

    exp_t sb[$];
    exp_t cur;
    exp_t exp_v;
    logic exp_stall;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] ADDI_X5   = 32'hFFD08293;
    localparam logic [31:0] LW_X6     = 32'h00012303;
    localparam logic [31:0] ADD_X7_X6 = 32'h003303B3;
    localparam logic [31:0] LW_X0     = 32'h00012003;
    localparam logic [31:0] ADD_X7_X0 = 32'h003003B3;
    localparam logic [31:0] BEQ_M8    = 32'hFE208CE3;
    localparam logic [31:0] ILL_7F    = 32'h00A0007F;

    function automatic void uses(input logic [31:0] ins, output logic u1, output logic u2);
        u1 = 1'b0;
        u2 = 1'b0;
        case (ins[6:0])
            7'h67, 7'h03, 7'h13: u1 = 1'b1;
            7'h23, 7'h63, 7'h33: begin u1 = 1'b1; u2 = 1'b1; end
            default: ;
        endcase
    endfunction

    function automatic exp_t model(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic wr;
        e          = '0;
        e.valid    = v;
        e.pc       = pc;
        e.rs1      = ins[19:15];
        e.rs2      = ins[24:20];
        e.rd       = ins[11:7];
        e.opcode   = ins[6:0];
        e.funct3   = ins[14:12];
        e.funct7b5 = ins[30];
        e.rs1_data = rf[ins[19:15]];
        e.rs2_data = rf[ins[24:20]];
        wr = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin e.imm = ins & 32'hFFFF_F000; wr = 1'b1; end
            7'h6F: begin
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                wr = 1'b1;
            end
            7'h67, 7'h03, 7'h13: begin
                e.imm = 32'($signed(ins[31:20]));
                wr = 1'b1;
                e.mem_read = (ins[6:0] == 7'h03);
            end
            7'h23: begin
                e.imm = 32'($signed({ins[31:25], ins[11:7]}));
                e.mem_write = 1'b1;
            end
            7'h63: e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h33: wr = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        e.reg_write = wr && (ins[11:7] != 5'd0);
        if (!v) begin
            e.reg_write = 1'b0;
            e.mem_read  = 1'b0;
            e.mem_write = 1'b0;
            e.illegal   = 1'b0;
        end
        return e;
    endfunction

    // Drives one cycle's inputs (rst_n high) and queues the predicted ID/EX contents.
    task automatic drive(input stim_t s);
        logic u1, u2, hz;
        exp_t nxt;
        if_valid = s.v;
        if_pc    = s.pc;
        if_instr = s.ins;
        flush_i  = s.fl;
        hold_i   = s.ho;
        uses(s.ins, u1, u2);
        hz = s.v && cur.valid && cur.mem_read && (cur.rd != 5'd0) &&
             ((u1 && cur.rd == s.ins[19:15]) || (u2 && cur.rd == s.ins[24:20]));
        exp_stall = !s.fl && (s.ho || hz);
        if (s.fl)      nxt = '0;
        else if (s.ho) nxt = cur;
        else if (hz)   nxt = '0;
        else           nxt = model(s.v, s.pc, s.ins);
        sb.push_back(nxt);
        cur = nxt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_valid = 1'b1; if_pc = 32'h40; if_instr = ADDI_X5; flush_i = 1'b0; hold_i = 1'b1;
        cur = '0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('0);
            #1;
            total++;
            if (stall_o !== 1'b0) begin
                $display("FAIL reset_stall got=%0b exp=0", stall_o); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL reset_idex got=%h exp=%h", obs, exp_v); bad++;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drive('{1'b1, 32'h100, ADDI_X5, 1'b0, 1'b0});
        #1;
        total++;
        if (stall_o !== exp_stall) begin
            $display("FAIL addi_stall got=%0b exp=%0b", stall_o, exp_stall); bad++;
        end
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v) begin
            $display("FAIL addi_idex got=%h exp=%h", obs, exp_v); bad++;
        end
        total++;
        if (idex_imm !== 32'hFFFF_FFFD || idex_rs1_data !== 32'd10 || idex_rd !== 5'd5 ||
            idex_reg_write !== 1'b1 || idex_valid !== 1'b1) begin
            $display("FAIL addi_fields got imm=%h d1=%h rd=%0d wr=%0b v=%0b exp imm=fffffffd d1=a rd=5 wr=1 v=1",
                     idex_imm, idex_rs1_data, idex_rd, idex_reg_write, idex_valid);
            bad++;
        end
    endtask

    task automatic test_load_use();
        stim_t st [4];
        logic exp_s [4];
        st = '{'{1'b1, 32'h200, LW_X6, 1'b0, 1'b0},
               '{1'b1, 32'h204, ADD_X7_X6, 1'b0, 1'b0},
               '{1'b1, 32'h204, ADD_X7_X6, 1'b0, 1'b0},
               '{1'b1, 32'h208, ADDI_X5, 1'b0, 1'b0}};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            #1;
            total++;
            if (stall_o !== exp_stall || stall_o !== exp_s[i]) begin
                $display("FAIL loaduse_stall[%0d] got=%0b exp=%0b", i, stall_o, exp_s[i]); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL loaduse_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
        end
    endtask

    task automatic test_x0_load();
        stim_t st [2];
        st = '{'{1'b1, 32'h300, LW_X0, 1'b0, 1'b0},
               '{1'b1, 32'h304, ADD_X7_X0, 1'b0, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            #1;
            total++;
            if (stall_o !== 1'b0) begin
                $display("FAIL x0load_stall[%0d] got=%0b exp=0", i, stall_o); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL x0load_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
            if (i == 0) begin
                total++;
                if (idex_reg_write !== 1'b0 || idex_mem_read !== 1'b1) begin
                    $display("FAIL x0load_wr got wr=%0b rd=%0b exp wr=0 rd=1", idex_reg_write, idex_mem_read);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_flush_hazard();
        stim_t st [3];
        st = '{'{1'b1, 32'h400, LW_X6, 1'b0, 1'b0},
               '{1'b1, 32'h404, ADD_X7_X6, 1'b1, 1'b1},
               '{1'b1, 32'h500, ADD_X7_X6, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            #1;
            total++;
            if (stall_o !== exp_stall) begin
                $display("FAIL flush_stall[%0d] got=%0b exp=%0b", i, stall_o, exp_stall); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL flush_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
        end
        total++;
        if (idex_valid !== 1'b1 || idex_rd !== 5'd7) begin
            $display("FAIL flush_after got v=%0b rd=%0d exp v=1 rd=7", idex_valid, idex_rd); bad++;
        end
    endtask

    task automatic test_hold();
        stim_t st [10];
        st = '{'{1'b1, 32'h600, ADDI_X5, 1'b0, 1'b0},
               '{1'b1, 32'h604, LW_X6, 1'b0, 1'b1},
               '{1'b1, 32'h608, BEQ_M8, 1'b0, 1'b1},
               '{1'b0, 32'h60C, ILL_7F, 1'b0, 1'b1},
               '{1'b1, 32'h604, LW_X6, 1'b0, 1'b0},
               '{1'b1, 32'h608, ADD_X7_X6, 1'b0, 1'b1},
               '{1'b1, 32'h608, ADD_X7_X6, 1'b0, 1'b1},
               '{1'b1, 32'h608, ADD_X7_X6, 1'b0, 1'b0},
               '{1'b1, 32'h608, ADD_X7_X6, 1'b0, 1'b0},
               '{1'b1, 32'h60C, ADDI_X5, 1'b0, 1'b0}};
        for (int i = 0; i < 10; i++) begin
            drive(st[i]);
            #1;
            total++;
            if (stall_o !== exp_stall) begin
                $display("FAIL hold_stall[%0d] got=%0b exp=%0b", i, stall_o, exp_stall); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL hold_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive('{1'b1, 32'h700, LW_X6, 1'b0, 1'b0});
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v) begin
            $display("FAIL rststall_load got=%h exp=%h", obs, exp_v); bad++;
        end
        drive('{1'b1, 32'h704, ADD_X7_X6, 1'b0, 1'b0});
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            $display("FAIL rststall_pre got=%0b exp=1", stall_o); bad++;
        end
        rst_n = 1'b0;
        void'(sb.pop_back());
        sb.push_back('0);
        cur = '0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            $display("FAIL rststall_comb got=%0b exp=0", stall_o); bad++;
        end
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v || stall_o !== 1'b0) begin
            $display("FAIL rststall_idex got=%h stall=%0b exp=%h stall=0", obs, stall_o, exp_v); bad++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_beq_illegal();
        stim_t st [2];
        st = '{'{1'b1, 32'h800, BEQ_M8, 1'b0, 1'b0},
               '{1'b1, 32'h804, ILL_7F, 1'b0, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            #1;
            total++;
            if (stall_o !== exp_stall) begin
                $display("FAIL beqill_stall[%0d] got=%0b exp=%0b", i, stall_o, exp_stall); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL beqill_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
            total++;
            if (i == 0 && (idex_imm !== 32'hFFFF_FFF8 || idex_reg_write !== 1'b0)) begin
                $display("FAIL beq_imm got imm=%h wr=%0b exp imm=fffffff8 wr=0", idex_imm, idex_reg_write); bad++;
            end else if (i == 1 && (idex_illegal !== 1'b1 || idex_valid !== 1'b1 || idex_reg_write !== 1'b0)) begin
                $display("FAIL illegal got ill=%0b v=%0b wr=%0b exp ill=1 v=1 wr=0", idex_illegal, idex_valid, idex_reg_write); bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pool [12];
        stim_t s;
        pool = '{ADDI_X5, LW_X6, ADD_X7_X6, LW_X0, ADD_X7_X0, BEQ_M8, ILL_7F,
                 32'h00612423, 32'h123452B7, 32'hFF5FF0EF, 32'h00430367, 32'h40628333};
        for (int i = 0; i < 80; i++) begin
            s.v   = ($urandom_range(0, 7) != 0);
            s.pc  = 32'h1000 + 32'(i * 4);
            s.ins = pool[$urandom_range(0, 11)];
            s.fl  = (i >= 20) && ($urandom_range(0, 9) == 0);
            s.ho  = (i >= 20) && ($urandom_range(0, 5) == 0);
            drive(s);
            #1;
            total++;
            if (stall_o !== exp_stall) begin
                $display("FAIL b2b_stall[%0d] got=%0b exp=%0b", i, stall_o, exp_stall); bad++;
            end
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                $display("FAIL b2b_idex[%0d] got=%h exp=%h", i, obs, exp_v); bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i * 32'h111);
        rf[0] = '0;
        rf[1] = 32'd10;
        rst_n = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_instr = '0; flush_i = 1'b0; hold_i = 1'b0;
        cur = '0;
        @(posedge clk); #1;
        test_reset();
        test_addi();
        test_load_use();
        test_x0_load();
        test_flush_hazard();
        test_hold();
        test_reset_mid_stall();
        test_beq_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline: sits between the IF/ID register and the execute stage. It decodes the instruction and drives the register-file read indices. It captures operands, immediate and control into the ID/EX pipeline register. It also detects load-use hazards and inserts bubbles, stalling fetch. Operand reads rely on the register file's same-cycle WB bypass, so no WB-to-ID hazard logic lives here.

## Interface
- No parameters (XLEN fixed at 32).
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk  in  1` — clock; all state updates on rising edge.
- `rst_n  in  1` — synchronous active-low reset.
- `if_valid  in  1` — IF/ID holds a real instruction.
- `if_pc  in  32` — PC of IF/ID instruction.
- `if_instr  in  32` — IF/ID instruction word.
- `r1_idx  out  5` — register-file read index 1 = `if_instr[19:15]`, combinational.
- `r2_idx  out  5` — register-file read index 2 = `if_instr[24:20]`, combinational.
- `reg1_data  in  32` — rs1 value from register file, same cycle.
- `reg2_data  in  32` — rs2 value from register file, same cycle.
- `flush_i  in  1` — EX redirect (taken branch/jump); kill the instruction in ID.
- `hold_i  in  1` — downstream not ready; freeze ID/EX.
- `stall_o  out  1` — combinational; IF must hold PC and IF/ID this cycle.
- ID/EX outputs (registered):
  - `idex_valid`, `idex_pc[31:0]`, `idex_rs1_data[31:0]`, `idex_rs2_data[31:0]`, `idex_imm[31:0]`
  - `idex_rs1[4:0]`, `idex_rs2[4:0]`, `idex_rd[4:0]`, `idex_opcode[6:0]`, `idex_funct3[2:0]`, `idex_funct7b5`
  - `idex_reg_write`, `idex_mem_read`, `idex_mem_write`, `idex_illegal`

## Operation
- Decode, by opcode:
  - LUI 0110111, AUIPC 0010111: U-imm = `{instr[31:12],12'b0}`; uses no rs.
  - JAL 1101111: J-imm; uses no rs.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I-imm; use rs1.
  - STORE 0100011: S-imm; uses rs1 and rs2.
  - BRANCH 1100011: B-imm; uses rs1 and rs2.
  - OP 0110011: imm = 0; uses rs1 and rs2.
- All immediates are sign-extended from `instr[31]`. B-imm and J-imm have bit 0 = 0.
- Control outputs:
  - `reg_write` = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and forced 0 when rd == 0.
  - `mem_read` = LOAD; `mem_write` = STORE.
- Any other opcode: `illegal` = 1, with reg_write, mem_read and mem_write all 0. The instruction still passes as valid so EX can trap.
- Load-use hazard (`hz`), all of the following true:
  - `if_valid`, `idex_valid` and `idex_mem_read` are 1;
  - `idex_rd != 0`;
  - `idex_rd` equals a source register the ID instruction actually uses (per the table above).
- Per-cycle priority, evaluated at the rising edge:
  1. `!rst_n`: every ID/EX field is cleared to 0. This applies even when reset lands mid-stall or mid-hold.
  2. `flush_i`: ID/EX becomes a bubble: `idex_valid=0`, `reg_write=0`, `mem_read=0`, `mem_write=0`; other fields don't-care (cleared to 0). Flush overrides `hold_i` and `hz`.
  3. `hold_i`: all ID/EX fields hold.
  4. `hz`: ID/EX becomes a bubble (same as flush).
  5. Otherwise ID/EX loads the decoded instruction, with `idex_valid = if_valid`. When `if_valid=0`, all control bits are loaded as 0.
- `stall_o = !flush_i && (hold_i || hz)`. `stall_o` is 0 while `rst_n=0`.
- A bubble clears `idex_mem_read`, so a hazard stalls for exactly one cycle. The next cycle re-decodes the same IF/ID instruction and finds no hazard.

## Timing
- Latency: one cycle from IF/ID to ID/EX.
- `r1_idx`, `r2_idx` and `stall_o` are combinational from `if_instr`, the ID/EX state and `flush_i`/`hold_i`.
- Operands are sampled from `reg1_data`/`reg2_data` on the same edge that loads ID/EX. WB-to-ID forwarding is therefore supplied by the register file; EX-stage forwarding belongs to EX.
- Reset value of every output, including `stall_o`: 0.
- Back-to-back instructions issue at 1 per cycle when no hazard, hold or flush is present.
- A hold followed by a hazard: the hazard is evaluated against the held ID/EX contents once the hold releases.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), x1 = 10, pc = 0x100 → next cycle:
  - `idex_valid=1`, `idex_imm=0xFFFFFFFD`, `idex_rs1_data=10`, `idex_rd=5`, `reg_write=1`, `stall_o=0`.
- LW x6,0(x2), then ADD x7,x6,x3:
  - ADD cycle: `stall_o=1` for 1 cycle, then ID/EX = bubble.
  - Following cycle: ADD is captured and `stall_o=0`.
- LW x0,0(x2), then ADD x7,x0,x3 → no stall; `idex_reg_write=0` for the LW.
- Hazard condition present with `flush_i=1` in the same cycle → `stall_o=0` and ID/EX bubble.
- `hold_i=1` for 3 cycles with new IF/ID words → ID/EX fields unchanged and `stall_o=1`. After release, the held IF/ID instruction is captured.
- `rst_n=0` asserted for one edge while stalled on a hazard → all outputs 0 and `stall_o=0`.
- BEQ imm = −8 (0xFE208CE3) → `idex_imm=0xFFFFFFF8`, `reg_write=0`.
- Opcode 0x7F → `idex_illegal=1`, `idex_valid=1`.
